// File: rtl/game_pkg.sv
// game_pkg: screen geometry, colours and scheduler states shared by the sprite pipeline.
package game_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int PLAYER_SIZE = 3;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    typedef enum logic [1:0] {IDLE, CLEAR, ERASE, DRAW} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters, searching from the slot after the last grant.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);
    logic [IW-1:0] last_gnt, cand;

    // Walk from farthest to nearest so the nearest requester after last_gnt wins.
    always_comb begin
        grant_idx = '0;
        grant_valid = 1'b0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_gnt) + k) % N);
            if (req[cand]) begin
                grant_idx = cand;
                grant_valid = 1'b1;
            end
        end
    end

    assign grant = grant_valid ? N'(1) << grant_idx : '0;

    always_ff @(posedge clk) begin
        if (!resetn)
            last_gnt <= IW'(N - 1);
        else if (advance)
            last_gnt <= grant_idx;
    end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: shares the VGA plot port among sprites, erasing each old square
// and drawing the new one pixel per cycle, plus a full-screen black fill on request.
module sprite_draw_scheduler
    import game_pkg::*;
#(
    parameter int N_SPRITES = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_SPRITES-1:0]   move,
    input  logic [8*N_SPRITES-1:0] pos_x,
    input  logic [7*N_SPRITES-1:0] pos_y,
    input  logic [3*N_SPRITES-1:0] size,
    input  logic [3*N_SPRITES-1:0] colour,
    input  logic                   clear_screen,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   plot,
    output logic                   busy
);
    localparam int IW = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;

    sched_state_t state;
    logic [N_SPRITES-1:0] pending, pending_next, old_valid, gnt_onehot;
    logic [7:0] old_x [N_SPRITES];
    logic [6:0] old_y [N_SPRITES];
    logic [2:0] old_size [N_SPRITES];
    logic [IW-1:0] gnt_idx, cur;
    logic gnt_valid, grant, no_work, erasing, last_px, last_py;
    logic [7:0] sx, cx;
    logic [6:0] sy, cy;
    logic [2:0] ssz, scol, px, py, sz;
    logic [8:0] pix_x;
    logic [7:0] pix_y;

    rr_arbiter #(.N(N_SPRITES)) u_arb (
        .clk(clk),
        .resetn(resetn),
        .req(pending),
        .advance(grant),
        .grant(gnt_onehot),
        .grant_idx(gnt_idx),
        .grant_valid(gnt_valid)
    );

    assign grant = state == IDLE && !clear_screen && gnt_valid;
    assign pending_next = (pending & ~(grant ? gnt_onehot : '0)) | move;
    // A grant with nothing to erase and nothing to draw completes inside the IDLE cycle.
    assign no_work = (!old_valid[gnt_idx] || old_size[gnt_idx] == 3'd0) && size[3*gnt_idx +: 3] == 3'd0;
    assign erasing = state == ERASE && old_valid[cur] && old_size[cur] != 3'd0;
    assign sz = erasing ? old_size[cur] : ssz;
    assign pix_x = {1'b0, erasing ? old_x[cur] : sx} + {6'd0, px};
    assign pix_y = {1'b0, erasing ? old_y[cur] : sy} + {5'd0, py};
    assign last_px = px == sz - 3'd1;
    assign last_py = py == sz - 3'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            pending <= '0;
            old_valid <= '0;
            vga_x <= '0;
            vga_y <= '0;
            vga_colour <= '0;
            plot <= 1'b0;
            busy <= 1'b0;
            cur <= '0;
            sx <= '0;
            sy <= '0;
            ssz <= '0;
            scol <= '0;
            px <= '0;
            py <= '0;
            cx <= '0;
            cy <= '0;
        end else begin
            pending <= pending_next;
            plot <= 1'b0;
            busy <= state != IDLE;
            case (state)
                IDLE: begin
                    if (clear_screen) begin
                        state <= CLEAR;
                        cx <= '0;
                        cy <= '0;
                        busy <= 1'b1;
                    end else if (gnt_valid) begin
                        cur <= gnt_idx;
                        sx <= pos_x[8*gnt_idx +: 8];
                        sy <= pos_y[7*gnt_idx +: 7];
                        ssz <= size[3*gnt_idx +: 3];
                        scol <= colour[3*gnt_idx +: 3];
                        px <= '0;
                        py <= '0;
                        if (no_work) begin
                            old_valid[gnt_idx] <= 1'b0;
                            busy <= |pending_next;
                        end else begin
                            state <= ERASE;
                            busy <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    vga_x <= cx;
                    vga_y <= cy;
                    vga_colour <= COLOUR_BLACK;
                    plot <= 1'b1;
                    if (clear_screen) begin
                        cx <= '0;
                        cy <= '0;
                    end else if (cx == 8'(SCREEN_W - 1)) begin
                        cx <= '0;
                        if (cy == 7'(SCREEN_H - 1)) begin
                            state <= IDLE;
                            old_valid <= '0;
                            pending <= '1;
                            busy <= 1'b1;
                        end else
                            cy <= cy + 7'd1;
                    end else
                        cx <= cx + 8'd1;
                end
                default: begin
                    vga_x <= pix_x[7:0];
                    vga_y <= pix_y[6:0];
                    vga_colour <= erasing ? COLOUR_BLACK : scol;
                    plot <= pix_x < 9'(SCREEN_W) && pix_y < 8'(SCREEN_H);
                    px <= last_px ? 3'd0 : px + 3'd1;
                    if (last_px)
                        py <= last_py ? 3'd0 : py + 3'd1;
                    if (clear_screen) begin
                        state <= CLEAR;
                        cx <= '0;
                        cy <= '0;
                        busy <= 1'b1;
                    end else if (last_px && last_py) begin
                        if (erasing && ssz != 3'd0)
                            state <= DRAW;
                        else if (erasing) begin
                            old_valid[cur] <= 1'b0;
                            state <= IDLE;
                            busy <= |pending_next;
                        end else begin
                            old_valid[cur] <= 1'b1;
                            old_x[cur] <= sx;
                            old_y[cur] <= sy;
                            old_size[cur] <= ssz;
                            state <= IDLE;
                            busy <= |pending_next;
                        end
                    end else
                        state <= erasing ? ERASE : DRAW;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: directed scenarios for the sprite draw scheduler with
// hand-computed pixel streams and service times.
module tb_sprite_draw_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clear_screen = 1'b0;
    logic [N-1:0] move = '0;
    logic [8*N-1:0] pos_x = '0;
    logic [7*N-1:0] pos_y = '0;
    logic [3*N-1:0] size = '0;
    logic [3*N-1:0] colour = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic plot, busy;

    int errors = 0;
    int checks = 0;
    logic [17:0] log_q[$];
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    sprite_draw_scheduler #(.N_SPRITES(N)) dut (
        .clk(clk),
        .resetn(resetn),
        .move(move),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .size(size),
        .colour(colour),
        .clear_screen(clear_screen),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_colour(vga_colour),
        .plot(plot),
        .busy(busy)
    );

    function automatic logic [17:0] px_at(input int x0, input int y0, input int s, input int k, input int c);
        return {8'(x0 + k % s), 7'(y0 + k / s), 3'(c)};
    endfunction

    task automatic set_sprite(input int i, input int x, input int y, input int s, input int c);
        pos_x[8*i +: 8] = 8'(x);
        pos_y[7*i +: 7] = 7'(y);
        size[3*i +: 3] = 3'(s);
        colour[3*i +: 3] = 3'(c);
    endtask

    task automatic pulse_move(input logic [N-1:0] m);
        @(negedge clk);
        move = m;
        @(negedge clk);
        move = '0;
    endtask

    task automatic step_log();
        @(negedge clk);
        if (plot) log_q.push_back({vga_x, vga_y, vga_colour});
    endtask

    // Steps until busy drops (bounded by limit), logging every plotted pixel.
    task automatic wait_idle(input int limit, output int n);
        n = 0;
        do begin
            step_log();
            n++;
        end while (busy && n < limit);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (vga_x !== 8'd0) begin errors++; $display("FAIL reset_vga_x got %0d want 0", vga_x); end
        checks++; if (vga_y !== 7'd0) begin errors++; $display("FAIL reset_vga_y got %0d want 0", vga_y); end
        checks++; if (vga_colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", vga_colour); end
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", plot); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_first_draw();
        int n;
        logic ok;
        set_sprite(0, 80, 115, 3, 5);
        log_q.delete();
        exp_q.delete();
        for (int k = 0; k < 9; k++) exp_q.push_back(px_at(80, 115, 3, k, 5));
        pulse_move(4'b0001);
        wait_idle(100, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL first_draw_cycles got %0d want 10", n); end
        checks++; if (log_q.size() !== 9) begin errors++; $display("FAIL first_draw_plots got %0d want 9", log_q.size()); end
        checks++;
        ok = 1'b1;
        foreach (exp_q[i]) if (ok && (i >= log_q.size() || log_q[i] !== exp_q[i])) begin
            ok = 1'b0;
            $display("FAIL first_draw_pixel idx %0d got %h want %h", i, i < log_q.size() ? log_q[i] : 18'h0, exp_q[i]);
        end
        if (!ok) errors++;
    endtask

    task automatic test_move_erase();
        int n;
        logic ok;
        set_sprite(0, 79, 115, 3, 5);
        log_q.delete();
        exp_q.delete();
        for (int k = 0; k < 9; k++) exp_q.push_back(px_at(80, 115, 3, k, 0));
        for (int k = 0; k < 9; k++) exp_q.push_back(px_at(79, 115, 3, k, 5));
        pulse_move(4'b0001);
        wait_idle(100, n);
        checks++; if (n !== 19) begin errors++; $display("FAIL move_cycles got %0d want 19", n); end
        checks++; if (log_q.size() !== 18) begin errors++; $display("FAIL move_plots got %0d want 18", log_q.size()); end
        checks++;
        ok = 1'b1;
        foreach (exp_q[i]) if (ok && (i >= log_q.size() || log_q[i] !== exp_q[i])) begin
            ok = 1'b0;
            $display("FAIL move_pixel idx %0d got %h want %h", i, i < log_q.size() ? log_q[i] : 18'h0, exp_q[i]);
        end
        if (!ok) errors++;
    endtask

    task automatic test_round_robin();
        int n;
        logic ok;
        set_sprite(1, 10, 10, 1, 1);
        set_sprite(2, 20, 10, 1, 2);
        set_sprite(3, 30, 10, 1, 3);
        pulse_move(4'b0010);
        wait_idle(100, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL rr_first_cycles got %0d want 2", n); end
        log_q.delete();
        exp_q.delete();
        exp_q.push_back({8'd20, 7'd10, 3'd2});
        exp_q.push_back({8'd30, 7'd10, 3'd3});
        exp_q.push_back({8'd10, 7'd10, 3'd0});
        exp_q.push_back({8'd10, 7'd10, 3'd1});
        pulse_move(4'b1110);
        wait_idle(100, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL rr_cycles got %0d want 7", n); end
        checks++;
        ok = log_q.size() == exp_q.size();
        if (!ok) $display("FAIL rr_order plots %0d want 4", log_q.size());
        foreach (exp_q[i]) if (ok && log_q[i] !== exp_q[i]) begin
            ok = 1'b0;
            $display("FAIL rr_order idx %0d got %h want %h", i, log_q[i], exp_q[i]);
        end
        if (!ok) errors++;
    endtask

    task automatic test_clip();
        int n;
        logic ok;
        set_sprite(2, 158, 118, 4, 2);
        log_q.delete();
        exp_q.delete();
        exp_q.push_back({8'd20, 7'd10, 3'd0});
        exp_q.push_back({8'd158, 7'd118, 3'd2});
        exp_q.push_back({8'd159, 7'd118, 3'd2});
        exp_q.push_back({8'd158, 7'd119, 3'd2});
        exp_q.push_back({8'd159, 7'd119, 3'd2});
        pulse_move(4'b0100);
        wait_idle(100, n);
        checks++; if (n !== 18) begin errors++; $display("FAIL clip_cycles got %0d want 18", n); end
        checks++; if (log_q.size() !== 5) begin errors++; $display("FAIL clip_plots got %0d want 5", log_q.size()); end
        checks++;
        ok = 1'b1;
        foreach (exp_q[i]) if (ok && (i >= log_q.size() || log_q[i] !== exp_q[i])) begin
            ok = 1'b0;
            $display("FAIL clip_pixel idx %0d got %h want %h", i, i < log_q.size() ? log_q[i] : 18'h0, exp_q[i]);
        end
        if (!ok) errors++;
    endtask

    task automatic test_clear_mid_draw();
        int n;
        logic ok;
        set_sprite(0, 50, 50, 3, 5);
        log_q.delete();
        exp_q.delete();
        for (int k = 0; k < 9; k++) exp_q.push_back(px_at(79, 115, 3, k, 0));
        for (int k = 0; k < 3; k++) exp_q.push_back(px_at(50, 50, 3, k, 5));
        for (int k = 0; k < 19200; k++) exp_q.push_back(px_at(0, 0, 160, k, 0));
        exp_q.push_back({8'd10, 7'd10, 3'd1});
        exp_q.push_back({8'd158, 7'd118, 3'd2});
        exp_q.push_back({8'd159, 7'd118, 3'd2});
        exp_q.push_back({8'd158, 7'd119, 3'd2});
        exp_q.push_back({8'd159, 7'd119, 3'd2});
        exp_q.push_back({8'd30, 7'd10, 3'd3});
        for (int k = 0; k < 9; k++) exp_q.push_back(px_at(50, 50, 3, k, 5));
        pulse_move(4'b0001);
        repeat (12) step_log();
        clear_screen = 1'b1;
        step_log();
        clear_screen = 1'b0;
        wait_idle(25000, n);
        checks++; if (n + 13 !== 19244) begin errors++; $display("FAIL clear_cycles got %0d want 19244", n + 13); end
        checks++; if (log_q.size() !== 19227) begin errors++; $display("FAIL clear_plots got %0d want 19227", log_q.size()); end
        checks++;
        if (log_q.size() <= 19211 || log_q[19211] !== {8'd159, 7'd119, 3'd0}) begin
            errors++;
            $display("FAIL clear_last_sweep got %h want %h", log_q.size() > 19211 ? log_q[19211] : 18'h0, {8'd159, 7'd119, 3'd0});
        end
        checks++;
        ok = 1'b1;
        foreach (exp_q[i]) if (ok && (i >= log_q.size() || log_q[i] !== exp_q[i])) begin
            ok = 1'b0;
            $display("FAIL clear_pixel idx %0d got %h want %h", i, i < log_q.size() ? log_q[i] : 18'h0, exp_q[i]);
        end
        if (!ok) errors++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic ok;
        log_q.delete();
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 9; k++) exp_q.push_back(px_at(50, 50, 3, k, 0));
            for (int k = 0; k < 9; k++) exp_q.push_back(px_at(50, 50, 3, k, 5));
        end
        // move[0] is held across the pending edge and the grant edge.
        @(negedge clk);
        move = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        move = '0;
        wait_idle(200, n);
        checks++; if (n !== 37) begin errors++; $display("FAIL b2b_cycles got %0d want 37", n); end
        checks++; if (log_q.size() !== 36) begin errors++; $display("FAIL b2b_plots got %0d want 36", log_q.size()); end
        checks++;
        ok = 1'b1;
        foreach (exp_q[i]) if (ok && (i >= log_q.size() || log_q[i] !== exp_q[i])) begin
            ok = 1'b0;
            $display("FAIL b2b_pixel idx %0d got %h want %h", i, i < log_q.size() ? log_q[i] : 18'h0, exp_q[i]);
        end
        if (!ok) errors++;
    endtask

    task automatic test_reset_mid_sweep();
        logic quiet;
        @(negedge clk);
        clear_screen = 1'b1;
        @(negedge clk);
        clear_screen = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b1 || plot !== 1'b1) begin errors++; $display("FAIL sweep_active got busy=%b plot=%b want 1 1", busy, plot); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (plot !== 1'b0 || busy !== 1'b0 || vga_x !== 8'd0) begin
            errors++;
            $display("FAIL reset_sweep got plot=%b busy=%b x=%0d want 0 0 0", plot, busy, vga_x);
        end
        resetn = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (plot !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL post_reset_quiet got %b want 1", quiet); end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_move_erase();
        test_round_robin();
        test_clip();
        test_clear_mid_draw();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
